// File: rtl/oled_pkg.sv
// Shared definitions for the OLED display path: panel geometry defaults,
// RGB565 colour constants, the pixel streamer state encoding and the
// colour-bar lookup used by the built-in test pattern.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    ADVANCE,
    GAP
  } streamer_state_t;

  // Four vertical bars selected by the top two column bits.
  function automatic logic [15:0] test_bar_colour(input logic [1:0] bar);
    logic [15:0] colour;
    case (bar)
      2'd0:    colour = RED;
      2'd1:    colour = GREEN;
      2'd2:    colour = BLUE;
      default: colour = WHITE;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/spi_tx_shift16.sv
// 16-bit MSB-first SPI transmitter, mode 3 (SCLK idles high).
// A load pulse captures a word; each bit is driven for CLK_DIV cycles with
// SCLK low, then held for CLK_DIV cycles with SCLK high so the panel samples
// on the rising edge. done is high during the final cycle of the last bit.
module spi_tx_shift16 #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] data,
  output logic        done,
  output logic        sclk,
  output logic        mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [15:0]      shifter;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             active;
  logic             high_half;
  logic             half_end;

  assign half_end = active && (div_cnt == DIV_LAST);

  // Divider, half-period phase, bit counter and shifter advance together;
  // the word moves left only after a bit's high half has completed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shifter   <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      active    <= 1'b0;
      high_half <= 1'b0;
    end else if (load) begin
      shifter   <= data;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      active    <= 1'b1;
      high_half <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!high_half) begin
          high_half <= 1'b1;
        end else begin
          high_half <= 1'b0;
          shifter   <= {shifter[14:0], 1'b0};
          if (bit_cnt == 4'd15) begin
            active  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign done = half_end && high_half && (bit_cnt == 4'd15);
  assign sclk = !(active && !high_half);
  // After 16 shifts the register is empty, so MOSI rests low between words.
  assign mosi = shifter[15];

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans (px, py) across the panel, samples the renderer's RGB565 word for
// each coordinate and streams it to the 96x64 OLED over 4-wire SPI, with a
// chip-select-high gap between frames. dc is tied high (pixel data only).
// Optional build macro OLED_STREAMER_TEST_PATTERN_EN replaces the renderer
// input with fixed colour bars taken from px[6:5]; timing is unchanged.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH     = OLED_WIDTH,
  parameter int HEIGHT    = OLED_HEIGHT,
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [6:0]  px,
  output logic [6:0]  py,
  input  logic [15:0] oled_data,
  output logic        frame_begin,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_dc
);

  localparam logic [6:0] PX_LAST = 7'(WIDTH - 1);
  localparam logic [6:0] PY_LAST = 7'(HEIGHT - 1);
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  streamer_state_t  state;
  streamer_state_t  state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;
  logic             last_pixel;
  logic             shift_load;
  logic             shift_done;
  logic [15:0]      pixel_word;

  assign gap_last   = (gap_cnt == GAP_LAST);
  assign last_pixel = (px == PX_LAST) && (py == PY_LAST);
  assign spi_dc     = 1'b1;

`ifdef OLED_STREAMER_TEST_PATTERN_EN
  assign pixel_word = test_bar_colour(px[6:5]);
`else
  assign pixel_word = oled_data;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing; chip select, busy and the frame pulse decode from state.
  always_comb begin
    state_next  = state;
    spi_cs_n    = 1'b1;
    busy        = 1'b0;
    frame_begin = 1'b0;
    shift_load  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        spi_cs_n    = 1'b0;
        busy        = 1'b1;
        shift_load  = 1'b1;
        frame_begin = (px == 7'd0) && (py == 7'd0);
        state_next  = SHIFT;
      end
      SHIFT: begin
        spi_cs_n = 1'b0;
        busy     = 1'b1;
        if (shift_done) begin
          state_next = ADVANCE;
        end
      end
      ADVANCE: begin
        spi_cs_n   = 1'b0;
        busy       = 1'b1;
        state_next = last_pixel ? GAP : FETCH;
      end
      GAP: begin
        if (gap_last) begin
          state_next = enable ? FETCH : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Raster coordinates move only in ADVANCE, so they are stable through FETCH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px <= '0;
      py <= '0;
    end else if (state == IDLE) begin
      px <= '0;
      py <= '0;
    end else if (state == ADVANCE) begin
      if (px != PX_LAST) begin
        px <= px + 7'd1;
      end else begin
        px <= '0;
        if (py != PY_LAST) begin
          py <= py + 7'd1;
        end else begin
          py <= '0;
        end
      end
    end
  end

  // Inter-frame gap length counter, cleared whenever the gap is not running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if ((state == GAP) && !gap_last) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  spi_tx_shift16 #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (shift_load),
    .data    (pixel_word),
    .done    (shift_done),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi)
  );

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 12x4 panel. Expected
// pixel words are queued per frame in raster order and compared against the
// words reassembled from MOSI on SCLK rising edges.
module tb_oled_pixel_streamer;

  localparam int TB_W         = 12;
  localparam int TB_H         = 4;
  localparam int TB_DIV       = 2;
  localparam int TB_GAP       = 16;
  localparam int PIXEL_CYCLES = 2 + 32 * TB_DIV;
  localparam int FRAME_LIMIT  = TB_W * TB_H * PIXEL_CYCLES + 200;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  px;
  logic [6:0]  py;
  logic [15:0] oled_data;
  logic        frame_begin;
  logic        busy;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_dc;

  int          render_mode = 0;
  int          checks = 0;
  int          failures = 0;
  int          words_rx = 0;
  logic [15:0] sb[$];

  // Renderer: constant red, or a word encoding the requested coordinate.
  assign oled_data = (render_mode == 0) ? 16'hF800 : {px, py, 2'b10};

  oled_pixel_streamer #(
    .WIDTH     (TB_W),
    .HEIGHT    (TB_H),
    .CLK_DIV   (TB_DIV),
    .FRAME_GAP (TB_GAP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .px          (px),
    .py          (py),
    .oled_data   (oled_data),
    .frame_begin (frame_begin),
    .busy        (busy),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_dc      (spi_dc)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [15:0] expWord(input int mode, input int x, input int y);
    logic [6:0] xv;
    logic [6:0] yv;
    xv = 7'(x);
    yv = 7'(y);
`ifdef OLED_STREAMER_TEST_PATTERN_EN
    case (xv[6:5])
      2'd0:    return 16'hF800;
      2'd1:    return 16'h07E0;
      2'd2:    return 16'h001F;
      default: return 16'hFFFF;
    endcase
`else
    if (mode == 0) return 16'hF800;
    return {xv, yv, 2'b10};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input int mode);
    enable      = en;
    render_mode = mode;
  endtask

  task automatic pushFrame(input int mode);
    for (int y = 0; y < TB_H; y++) begin
      for (int x = 0; x < TB_W; x++) begin
        sb.push_back(expWord(mode, x, y));
      end
    end
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_cs_n"}, {31'd0, spi_cs_n}, 32'd1);
    checkOutput({phase, "_sclk"}, {31'd0, spi_sclk}, 32'd1);
    checkOutput({phase, "_mosi"}, {31'd0, spi_mosi}, 32'd0);
    checkOutput({phase, "_dc"}, {31'd0, spi_dc}, 32'd1);
    checkOutput({phase, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({phase, "_frame_begin"}, {31'd0, frame_begin}, 32'd0);
    checkOutput({phase, "_px"}, {25'd0, px}, 32'd0);
    checkOutput({phase, "_py"}, {25'd0, py}, 32'd0);
  endtask

  // Reassembles words from MOSI on each SCLK rise while chip select is low.
  task automatic monitorSpi();
    logic        prev_sclk;
    logic [15:0] word;
    logic [15:0] exp;
    int          nbits;
    prev_sclk = 1'b1;
    word      = '0;
    nbits     = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_sclk = 1'b1;
        nbits     = 0;
      end else begin
        if (!prev_sclk && spi_sclk && !spi_cs_n) begin
          word = {word[14:0], spi_mosi};
          nbits++;
          if (nbits == 16) begin
            nbits = 0;
            words_rx++;
            if (sb.size() != 0) exp = sb.pop_front();
            else exp = 16'hxxxx;
            checkOutput("spi_word", {16'd0, word}, {16'd0, exp});
          end
        end
        prev_sclk = spi_sclk;
      end
    end
  endtask

  initial begin
    int cnt;
    int fb_cnt;
    int low_cnt;

    fork
      monitorSpi();
    join_none

    // Held in reset with enable already high.
    applyStimulus(1'b1, 0);
    repeat (3) @(negedge clock);
    checkResetOutputs("reset");

    // Frame 1: constant red renderer.
    pushFrame(0);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_cs_n_after_release", {31'd0, spi_cs_n}, 32'd1);
    @(negedge clock);
    checkOutput("first_fetch_cs_n", {31'd0, spi_cs_n}, 32'd0);
    checkOutput("first_fetch_frame_begin", {31'd0, frame_begin}, 32'd1);
    checkOutput("first_fetch_busy", {31'd0, busy}, 32'd1);
    checkOutput("first_fetch_px", {25'd0, px}, 32'd0);
    checkOutput("first_fetch_py", {25'd0, py}, 32'd0);
    @(negedge clock);
    checkOutput("shift_frame_begin_low", {31'd0, frame_begin}, 32'd0);
    checkOutput("shift_first_sclk", {31'd0, spi_sclk}, 32'd0);
    checkOutput("shift_first_mosi", {31'd0, spi_mosi}, 32'd1);

    cnt = 1;
    while (px != 7'd1 && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("pixel_period", cnt, PIXEL_CYCLES);

    cnt = 0;
    while (busy && cnt < FRAME_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("frame1_end_in_time", {31'd0, cnt < FRAME_LIMIT}, 32'd1);
    checkOutput("frame1_sb_drained", sb.size(), 32'd0);
    checkOutput("gap_px", {25'd0, px}, 32'd0);
    checkOutput("gap_py", {25'd0, py}, 32'd0);

    // Frame 2: coordinate renderer, gap length measured on the way in.
    applyStimulus(1'b1, 1);
    pushFrame(1);
    cnt = 0;
    while (spi_cs_n && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    checkOutput("gap_cs_n_cycles", cnt, TB_GAP);
    checkOutput("frame2_frame_begin", {31'd0, frame_begin}, 32'd1);

    // Drop enable mid-frame; the frame must still finish.
    cnt = 0;
    while (!(px == 7'd5 && py == 7'd2) && cnt < FRAME_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("reach_pixel_5_2", {31'd0, cnt < FRAME_LIMIT}, 32'd1);
    applyStimulus(1'b0, 1);
    cnt = 0;
    while (busy && cnt < FRAME_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("frame2_end_in_time", {31'd0, cnt < FRAME_LIMIT}, 32'd1);
    checkOutput("frame2_sb_drained", sb.size(), 32'd0);
    checkOutput("words_after_two_frames", words_rx, 2 * TB_W * TB_H);

    fb_cnt  = 0;
    low_cnt = 0;
    repeat (TB_GAP + 40) begin
      @(negedge clock);
      fb_cnt  += int'(frame_begin);
      low_cnt += int'(!spi_cs_n);
    end
    checkOutput("idle_no_frame_begin", fb_cnt, 32'd0);
    checkOutput("idle_no_cs_low", low_cnt, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_sclk", {31'd0, spi_sclk}, 32'd1);

    // Frame 3: interrupted by reset partway through a pixel's shift.
    pushFrame(1);
    applyStimulus(1'b1, 1);
    cnt = 0;
    while (!frame_begin && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("frame3_begin_seen", {31'd0, frame_begin}, 32'd1);
    cnt = 0;
    while (px != 7'd3 && cnt < FRAME_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("reach_pixel_3", {25'd0, px}, 32'd3);
    repeat (7) @(negedge clock);
    checkOutput("mid_shift_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    sb.delete();
    repeat (3) @(negedge clock);

    // Frame 4: restart from (0,0) after release, run to completion.
    pushFrame(1);
    reset_n = 1'b1;
    cnt = 0;
    while (!frame_begin && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("restart_frame_begin", {31'd0, frame_begin}, 32'd1);
    checkOutput("restart_px", {25'd0, px}, 32'd0);
    checkOutput("restart_py", {25'd0, py}, 32'd0);
    cnt = 0;
    while (busy && cnt < FRAME_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("frame4_end_in_time", {31'd0, cnt < FRAME_LIMIT}, 32'd1);
    checkOutput("frame4_sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_pixel_streamer.md
Name: oled_pixel_streamer

Overview:
- Display-side counterpart of the pixel renderers: scans pixel coordinates (px, py) out to the combinational draw logic and samples the returned oled_data.
- Serialises each 16-bit RGB565 pixel MSB-first over a 4-wire SPI link to the 96x64 OLED panel, frame after frame.
- Sits between the top-level draw mux and the Pmod OLED pins; panel init/command traffic is out of scope (dc held high = data).

Parameters:
- WIDTH, 96, pixels per row; px wraps at WIDTH-1.
- HEIGHT, 64, rows per frame; py wraps at HEIGHT-1.
- CLK_DIV, 2, clock cycles per SCLK half-period (min 1).
- FRAME_GAP, 16, clock cycles with cs_n high between frames (min 1).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits a new frame to start; sampled only at frame boundaries.
- px  out  7  current column, registered.
- py  out  7  current row, registered.
- oled_data  in  16  RGB565 pixel for (px, py), combinational from the renderer.
- frame_begin  out  1  one-cycle pulse on the first FETCH of each frame.
- busy  out  1  high from frame start until GAP is entered.
- spi_cs_n  out  1  chip select, low for the whole frame.
- spi_sclk  out  1  SPI clock, idle high (mode 3).
- spi_mosi  out  1  serial data, MSB first.
- spi_dc  out  1  data/command; constant 1.

Behaviour:
- Reset values: px=0, py=0, frame_begin=0, busy=0, spi_cs_n=1, spi_sclk=1, spi_mosi=0, spi_dc=1, state=IDLE, shift register=0, bit count=0, divider=0.
- States: IDLE, FETCH, SHIFT, ADVANCE, GAP.
- IDLE: cs_n=1, sclk=1. If enable=1, go to FETCH next cycle with px=py=0.
- FETCH: one cycle. cs_n=0. Latch oled_data into the 16-bit shifter; px/py have been stable for at least one cycle before this. frame_begin=1 only if px=0 and py=0. Go to SHIFT.
- SHIFT: 16 bits, 2*CLK_DIV cycles each.
  - First half: sclk=0, mosi=current MSB.
  - Second half: sclk=1; the panel samples on the rising edge.
  - Shift left after each bit. After bit 0's high half, go to ADVANCE.
- ADVANCE: one cycle, sclk=1, cs_n stays low.
  - px<WIDTH-1: px++, go to FETCH.
  - Else px=0. If py<HEIGHT-1: py++, go to FETCH.
  - Else py=0, go to GAP.
- GAP: cs_n=1, busy=0, for FRAME_GAP cycles. Then go to FETCH if enable=1, else IDLE.
- Pixel period: 2 + 32*CLK_DIV cycles (66 at default). Frame: WIDTH*HEIGHT pixels.
- Deasserting enable mid-frame has no effect until the frame completes.
- An oled_data change during SHIFT has no effect; only the FETCH sample is sent.
- Asynchronous reset mid-frame returns all outputs to reset values immediately. The next frame restarts at (0,0) from IDLE.
- Counters never exceed the WIDTH-1/HEIGHT-1 bounds. Bit count and divider use minimal widths; no overflow is possible.

Optional Feature:
- Macro: OLED_STREAMER_TEST_PATTERN_EN.
- Defined: oled_data is ignored. FETCH latches a colour bar from px[6:5]: 0 = F800 (red), 1 = 07E0 (green), 2 = 001F (blue), 3 = FFFF (white).
- Undefined: oled_data is sampled as specified.
- Timing is identical in both cases.

Decomposition:
- Shared package oled_pkg: OLED_WIDTH/OLED_HEIGHT defaults, RGB565 colour constants (BLACK, WHITE, RED, GREEN, BLUE, MAGENTA), and the state enum for this block.
- Sub-module spi_tx_shift16: divider, bit counter and shifter. Interface: load, data[15:0], done, sclk, mosi.
- The top-level FSM owns px/py, cs_n and frame sequencing.

Test Plan:
- Reset with enable=1, release -> cs_n=1 until the first FETCH; frame_begin pulses once with px=py=0; cs_n falls the same cycle.
- Renderer returns constant F800 -> MOSI bits across the first 16 SCLK rising edges decode to 1111100000000000; the first pixel spans 66 cycles at CLK_DIV=2.
- Renderer returns {px,py} pattern -> the SPI monitor reconstructs 6144 words in raster order; (95,0) is followed by (0,1); (95,63) is followed by GAP with cs_n=1 for exactly 16 cycles.
- Drop enable at pixel (40,10) -> the frame completes to (95,63), then IDLE with busy=0, sclk=1, no further frame_begin.
- Assert reset_n=0 mid-SHIFT -> all outputs take reset values in the same cycle without a clock edge; after release, the next frame starts at (0,0).
- OLED_STREAMER_TEST_PATTERN_EN defined, oled_data=0000 -> px 0..31 send F800, 32..63 send 07E0, 64..95 send 001F.
